// File: rtl/sce_ramarb.sv
// Round-robin arbiter for one single-port SCE working RAM; zero-cycle grant, reads return after RDLAT cycles.
// Losers stall with req held; a locked owner or secmode (sequencer only) blocks the others.
module sce_ramarb #(
   parameter int NREQ  = 3,
   parameter int AW    = 12,
   parameter int DW    = 36,
   parameter int RDLAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               secmode,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic               ram_cs,
   output logic               ram_we,
   output logic [AW-1:0]      ram_addr,
   output logic [DW-1:0]      ram_wdata,
   input  logic [DW-1:0]      ram_rdata,
   output logic               owner_lock
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {ARB, LOCK} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [PW-1:0]   owner, owner_nxt;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt_c;
   logic            found;
   logic [NREQ-1:0] rd_pipe [RDLAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB;
         ptr   <= '0;
         owner <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      elig      = req;
      gnt_c     = '0;
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      found     = 1'b0;
      if (secmode) elig = req & {{(NREQ-1){1'b0}}, 1'b1};
      case (state)
         ARB: begin
            for (int k = 0; k < NREQ; k++) begin
               int idx;
               idx = int'(ptr) + k;
               if (idx >= NREQ) idx = idx - NREQ;
               if (!found && elig[idx]) begin
                  found      = 1'b1;
                  gnt_c[idx] = 1'b1;
                  ptr_nxt    = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
                  if (lock[idx]) begin
                     state_nxt = LOCK;
                     owner_nxt = PW'(idx);
                  end
               end
            end
         end
         LOCK: begin
            // A non-sequencer owner loses the RAM the moment secmode appears.
            if (secmode && owner != '0) begin
               state_nxt = ARB;
            end else begin
               gnt_c[owner] = elig[owner];
               if (!lock[owner] || !req[owner]) state_nxt = ARB;
            end
         end
         default: state_nxt = ARB;
      endcase
      if (reset) gnt_c = '0;
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_c[i]) begin
            ram_we    = we[i];
            ram_addr  = addr[i*AW +: AW];
            ram_wdata = wdata[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < RDLAT; s++) rd_pipe[s] <= '0;
      end else begin
         rd_pipe[0] <= gnt_c & ~we;
         for (int s = 1; s < RDLAT; s++) rd_pipe[s] <= rd_pipe[s-1];
      end
   end

   assign gnt        = gnt_c;
   assign ram_cs     = |gnt_c;
   assign rvalid     = rd_pipe[RDLAT-1];
   assign rdata      = ram_rdata;
   assign owner_lock = (state == LOCK);

endmodule

// File: tb/tb_sce_ramarb.sv
// Directed bench: RDLAT=1 instance for arbitration/lock/secmode/write, RDLAT=3 instance for reset mid-read.
module tb_sce_ramarb;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, secmode;
   logic [2:0]   req, lock, we;
   logic [35:0]  addr;
   logic [107:0] wdata;
   logic [2:0]   gnt, rvalid;
   logic [35:0]  rdata, ram_wdata, ram_rdata;
   logic         ram_cs, ram_we, owner_lock;
   logic [11:0]  ram_addr;

   logic         r3, s3;
   logic [2:0]   req3, lock3, we3;
   logic [35:0]  addr3;
   logic [107:0] wdata3;
   logic [2:0]   gnt3, rvalid3;
   logic [35:0]  rdata3, ram_wdata3, ram_rdata3;
   logic         ram_cs3, ram_we3, owner_lock3;
   logic [11:0]  ram_addr3;

   int checks = 0;
   int errors = 0;

   sce_ramarb #(.NREQ(3), .AW(12), .DW(36), .RDLAT(1)) dut (
      .clk(clk), .reset(reset), .secmode(secmode), .req(req), .lock(lock), .we(we),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .owner_lock(owner_lock)
   );

   sce_ramarb #(.NREQ(3), .AW(12), .DW(36), .RDLAT(3)) dut3 (
      .clk(clk), .reset(r3), .secmode(s3), .req(req3), .lock(lock3), .we(we3),
      .addr(addr3), .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
      .ram_cs(ram_cs3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
      .ram_rdata(ram_rdata3), .owner_lock(owner_lock3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; secmode = 1'b0; req = '0; lock = '0; we = '0;
      addr = '0; wdata = '0; ram_rdata = '0;
      r3 = 1'b1; s3 = 1'b0; req3 = '0; lock3 = '0; we3 = '0;
      addr3 = '0; wdata3 = '0; ram_rdata3 = '0;
      tick; tick;

      // gnt held at zero while reset is asserted even with requests present
      req = 3'b111; #1;
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_cs", 64'(ram_cs), 64'h0);
      req = 3'b000; reset = 1'b0; r3 = 1'b0;
      tick;
      chk("post_rst_gnt", 64'(gnt), 64'h0);
      chk("post_rst_rvalid", 64'(rvalid), 64'h0);
      chk("post_rst_lock", 64'(owner_lock), 64'h0);
      chk("post_rst_addr", 64'(ram_addr), 64'h0);
      chk("post_rst_we", 64'(ram_we), 64'h0);

      // 1: round robin across three held reads
      addr[0 +: 12] = 12'h100; addr[12 +: 12] = 12'h200; addr[24 +: 12] = 12'h300;
      req = 3'b111; ram_rdata = 36'h1_11111111; #1;
      chk("rr_g0", 64'(gnt), 64'h1);
      chk("rr_a0", 64'(ram_addr), 64'h100);
      chk("rr_cs0", 64'(ram_cs), 64'h1);
      chk("rr_v0", 64'(rvalid), 64'h0);
      tick;
      chk("rr_g1", 64'(gnt), 64'h2);
      chk("rr_a1", 64'(ram_addr), 64'h200);
      chk("rr_v1", 64'(rvalid), 64'h1);
      chk("rr_d1", 64'(rdata), 64'h1_11111111);
      tick;
      chk("rr_g2", 64'(gnt), 64'h4);
      chk("rr_v2", 64'(rvalid), 64'h2);
      tick;
      chk("rr_g3", 64'(gnt), 64'h1);
      chk("rr_v3", 64'(rvalid), 64'h4);
      tick;
      req = 3'b000; ram_rdata = 36'h2_22222222; #1;
      chk("rr_idle_g", 64'(gnt), 64'h0);
      chk("rr_v4", 64'(rvalid), 64'h1);
      chk("rr_d4", 64'(rdata), 64'h2_22222222);
      tick;

      // 2: requester 1 locks for four writes (ptr=1 after test 1)
      req = 3'b111; lock = 3'b010; we = 3'b111;
      wdata[36 +: 36] = 36'hC_00000000;
      for (int k = 0; k < 4; k++) begin
         addr[12 +: 12] = 12'h010 + 12'(k);
         if (k == 3) lock = 3'b000;
         #1;
         chk("lk_gnt", 64'(gnt), 64'h2);
         chk("lk_addr", 64'(ram_addr), 64'h010 + 64'(k));
         chk("lk_we", 64'(ram_we), 64'h1);
         chk("lk_own", 64'(owner_lock), (k == 0) ? 64'h0 : 64'h1);
         chk("lk_rv", 64'(rvalid), 64'h0);
         tick;
      end
      chk("lk_next", 64'(gnt), 64'h4);
      chk("lk_rel", 64'(owner_lock), 64'h0);
      tick;
      req = 3'b000; we = 3'b000; #1;
      tick;

      // 3: secmode blocks everyone but requester 0 (ptr=0)
      secmode = 1'b1; req = 3'b110; #1;
      chk("sec_block0", 64'(gnt), 64'h0);
      tick;
      chk("sec_block1", 64'(gnt), 64'h0);
      tick;
      chk("sec_block2", 64'(ram_cs), 64'h0);
      req = 3'b111; #1;
      chk("sec_g0", 64'(gnt), 64'h1);
      tick;
      req = 3'b000; secmode = 1'b0; #1;
      chk("sec_rv", 64'(rvalid), 64'h1);
      tick;

      // 4: requester 2 owns the RAM, then secmode evicts it (ptr=1)
      req = 3'b100; lock = 3'b100; #1;
      chk("ev_g", 64'(gnt), 64'h4);
      tick;
      chk("ev_own", 64'(owner_lock), 64'h1);
      chk("ev_g2", 64'(gnt), 64'h4);
      tick;
      secmode = 1'b1; req = 3'b101; #1;
      chk("ev_kill", 64'(gnt), 64'h0);
      chk("ev_inflight", 64'(rvalid), 64'h4);
      tick;
      chk("ev_unlock", 64'(owner_lock), 64'h0);
      chk("ev_seq", 64'(gnt), 64'h1);
      chk("ev_rv0", 64'(rvalid), 64'h0);
      tick;
      req = 3'b000; lock = 3'b000; secmode = 1'b0; #1;
      tick;

      // 6: full-width write at top address
      req = 3'b100; we = 3'b100; addr[24 +: 12] = 12'hFFF; wdata[72 +: 36] = 36'h5_A5A5A5A5; #1;
      chk("wr_g", 64'(gnt), 64'h4);
      chk("wr_cs", 64'(ram_cs), 64'h1);
      chk("wr_we", 64'(ram_we), 64'h1);
      chk("wr_addr", 64'(ram_addr), 64'hFFF);
      chk("wr_data", 64'(ram_wdata), 64'h5_A5A5A5A5);
      tick;
      req = 3'b000; we = 3'b000; #1;
      chk("wr_norv", 64'(rvalid), 64'h0);
      chk("wr_idle_we", 64'(ram_we), 64'h0);

      // 5: RDLAT=3, reset lands one cycle after a read grant
      addr3[12 +: 12] = 12'h044; req3 = 3'b010; #1;
      chk("r3_g", 64'(gnt3), 64'h2);
      tick;
      r3 = 1'b1; req3 = 3'b000; #1;
      chk("r3_rst_cs", 64'(ram_cs3), 64'h0);
      tick;
      r3 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("r3_drop", 64'(rvalid3), 64'h0);
         tick;
      end
      req3 = 3'b010; ram_rdata3 = 36'h3_33333333; #1;
      chk("r3_regnt", 64'(gnt3), 64'h2);
      tick;
      req3 = 3'b000; #1;
      chk("r3_lat1", 64'(rvalid3), 64'h0);
      tick;
      chk("r3_lat2", 64'(rvalid3), 64'h0);
      tick;
      chk("r3_lat3", 64'(rvalid3), 64'h2);
      chk("r3_data", 64'(rdata3), 64'h3_33333333);
      tick;
      chk("r3_lat4", 64'(rvalid3), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
